// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one single-cycle 32x32 multiplier among NREQ requesters.
// Define MUL_ARB_SIGNED_EN to add per-request signed operands (req_signed).
module mul_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
`ifdef MUL_ARB_SIGNED_EN
  input  logic [NREQ-1:0]      req_signed,
`endif
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [63:0]          rsp_y,
  output logic                 busy
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] last_grant, gnt;
  logic found;
  int j;
  logic [31:0] op_a, op_b, raw_a, raw_b, mag_a, mag_b;
  logic neg, sel_neg;
  // first valid requester after last_grant, wrapping
  always_comb begin
    found = 1'b0;
    gnt = '0;
    j = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last_grant) + k;
      j = (j >= NREQ) ? j - NREQ : j;
      if (!found && req_valid[IW'(j)]) begin
        found = 1'b1;
        gnt = IW'(j);
      end
    end
  end
  assign raw_a = req_a[32*gnt +: 32];
  assign raw_b = req_b[32*gnt +: 32];
`ifdef MUL_ARB_SIGNED_EN
  // signed requests multiply magnitudes; 0x80000000 stays 0x80000000 as unsigned
  assign mag_a = (req_signed[gnt] && raw_a[31]) ? -raw_a : raw_a;
  assign mag_b = (req_signed[gnt] && raw_b[31]) ? -raw_b : raw_b;
  assign sel_neg = req_signed[gnt] && (raw_a[31] ^ raw_b[31]);
`else
  assign mag_a = raw_a;
  assign mag_b = raw_b;
  assign sel_neg = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= IW'(NREQ - 1);
      op_a <= '0;
      op_b <= '0;
      neg <= 1'b0;
      rsp_id <= '0;
      rsp_y <= '0;
    end else begin
      if (state == IDLE && found) begin
        state <= EXEC;
        last_grant <= gnt;
        rsp_id <= gnt;
        op_a <= mag_a;
        op_b <= mag_b;
        neg <= sel_neg;
      end
      if (state == EXEC) begin
        state <= RESP;
        rsp_y <= neg ? -mul_y : mul_y;
      end
      if (state == RESP && rsp_ready) state <= IDLE;
    end
  end
  assign req_ready = (state == IDLE && found) ? NREQ'(1) << gnt : '0;
  assign mul_a = op_a;
  assign mul_b = op_b;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed + randomized scoreboard bench for mul_arbiter against a round-robin/product reference model.
module tb_mul_arbiter;
  localparam int NREQ = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid, req_ready, req_signed;
  logic [32*NREQ-1:0] req_a, req_b;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_y, rsp_y;
  logic rsp_valid, rsp_ready, busy;
  logic [IW-1:0] rsp_id;
  typedef struct { int id; logic [63:0] y; } exp_t;
  exp_t q[$];
  int gord[$];
  int tests = 0, failed = 0, cyc = 0, gcyc = 0, ptr = NREQ - 1, hs_cnt = 0, last_id = -1;
  bit out = 0, chk_rst = 0, hold = 0;
  logic [NREQ-1:0] taken = '0;
  logic [31:0] cur_a = '0, cur_b = '0;
  logic [63:0] last_y = '0;

  always #5 clk = ~clk;
  assign mul_y = {32'b0, mul_a} * {32'b0, mul_b};

  mul_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef MUL_ARB_SIGNED_EN
    .req_signed(req_signed),
`endif
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor + reference model, sampled on the falling edge
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [31:0] a, b;
    logic [63:0] sa, sb;
    bit was_out, s;
    cyc++;
    if (reset) begin
      q.delete();
      out = 0;
      ptr = NREQ - 1;
      chk_rst = 1;
      cur_a = '0;
      cur_b = '0;
    end else begin
      was_out = out;
      if (chk_rst) begin
        chk("reset rsp_y", rsp_y, 64'd0);
        chk("reset rsp_id", 64'(rsp_id), 64'd0);
        chk_rst = 0;
      end
      chk("busy", 64'(busy), 64'(was_out));
      chk("rsp_valid", 64'(rsp_valid), 64'(was_out && (cyc - gcyc >= 2)));
      chk("mul_a", 64'(mul_a), 64'(cur_a));
      chk("mul_b", 64'(mul_b), 64'(cur_b));
      if (rsp_valid && rsp_ready) hs_cnt++;
      if (rsp_valid && was_out && q.size() > 0) begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_y", rsp_y, q[0].y);
        if (rsp_ready) begin
          last_y = rsp_y;
          last_id = int'(rsp_id);
          void'(q.pop_front());
          out = 0;
        end
      end
      exp_rdy = '0;
      if (!was_out)
        for (int k = 1; k <= NREQ; k++)
          if (exp_rdy == 0 && req_valid[(ptr + k) % NREQ]) exp_rdy[(ptr + k) % NREQ] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int g = 0; g < NREQ; g++)
        if (exp_rdy[g]) begin
          a = req_a[32*g +: 32];
          b = req_b[32*g +: 32];
          s = req_signed[g];
          sa = s ? {{32{a[31]}}, a} : {32'b0, a};
          sb = s ? {{32{b[31]}}, b} : {32'b0, b};
          q.push_back('{g, sa * sb});
`ifdef MUL_ARB_SIGNED_EN
          cur_a = (s && a[31]) ? -a : a;
          cur_b = (s && b[31]) ? -b : b;
`else
          cur_a = a;
          cur_b = b;
`endif
          out = 1;
          ptr = g;
          gcyc = cyc;
          taken[g] = 1'b1;
          gord.push_back(g);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (taken[i]) begin
        taken[i] = 1'b0;
        if (!hold) req_valid[i] = 1'b0;
      end
  endtask

  task automatic setreq(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n0;
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_signed = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    // single request, fixed latency
    setreq(0, 32'd3, 32'd5);
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("s034 y", last_y, 64'd15);
    chk("s034 id", 64'(last_id), 64'd0);
    // all four held: rotation 0,1,2,3,0
    do_reset();
    gord.delete();
    hold = 1;
    for (int i = 0; i < NREQ; i++) setreq(i, 32'(i + 2), 32'(i + 7));
    repeat (18) tick();
    hold = 0;
    req_valid = '0;
    repeat (6) tick();
    for (int k = 0; k < 5; k++) chk("s035 order", 64'(k < gord.size() ? gord[k] : -1), 64'(k % 4));
    // max operands, back-pressured response
    do_reset();
    setreq(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rsp_ready = 1'b0;
    tick();
    setreq(2, 32'd4, 32'd6);
    setreq(3, 32'd8, 32'd9);
    repeat (7) tick();
    rsp_ready = 1'b1;
    tick();
    chk("s036 y", last_y, 64'hFFFF_FFFE_0000_0001);
    chk("s036 id", 64'(last_id), 64'd1);
    repeat (10) tick();
    // reset during EXEC aborts the request
    do_reset();
    setreq(0, 32'd7, 32'd9);
    rsp_ready = 1'b1;
    tick();
    n0 = hs_cnt;
    do_reset();
    repeat (6) tick();
    chk("s037 no rsp", 64'(hs_cnt), 64'(n0));
    // late request during RESP, pointer wraps to requester 1
    do_reset();
    gord.delete();
    rsp_ready = 1'b0;
    setreq(2, 32'd11, 32'd13);
    repeat (2) tick();
    setreq(1, 32'd17, 32'd19);
    repeat (2) tick();
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("s039 first", 64'(gord.size() > 0 ? gord[0] : -1), 64'd2);
    chk("s039 next", 64'(gord.size() > 1 ? gord[1] : -1), 64'd1);
`ifdef MUL_ARB_SIGNED_EN
    do_reset();
    req_signed[0] = 1'b1;
    setreq(0, 32'hFFFF_FFFD, 32'd5);
    repeat (5) tick();
    chk("s038 signed", last_y, 64'hFFFF_FFFF_FFFF_FFF1);
    req_signed[0] = 1'b0;
    setreq(0, 32'hFFFF_FFFD, 32'd5);
    repeat (5) tick();
    chk("s038 unsigned", last_y, 64'h0000_0004_FFFF_FFF1);
`endif
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rsp_ready = $urandom_range(2) != 0;
      for (int i = 0; i < NREQ; i++) begin
`ifdef MUL_ARB_SIGNED_EN
        req_signed[i] = 1'($urandom_range(1));
`endif
        if (!req_valid[i] && $urandom_range(3) == 0) setreq(i, pick(), pick());
        else if (req_valid[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) tick();
    chk("drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
